// File: rtl/cim_ctrl_pkg.sv
// cim_ctrl_pkg: shared command encodings, scheduler states and default widths for the CIM macro scheduler
package cim_ctrl_pkg;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CIM_IN_W   = 64;
    localparam int DEF_CIM_OUT_W  = 128;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_CIM   = 2'd2,
        OP_RSVD  = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ISSUE,
        RD_CAP,
        CIM_ISSUE,
        CIM_CAP,
        RESP
    } state_e;
endpackage

// File: rtl/cim_macro_scheduler.sv
// cim_macro_scheduler: sequences write bursts, reads and compute ops onto a CIM SRAM macro
module cim_macro_scheduler
    import cim_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CIM_IN_W   = DEF_CIM_IN_W,
    parameter int CIM_OUT_W  = DEF_CIM_OUT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    input  logic [CIM_IN_W-1:0]   cmd_cim_in,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_is_cim,
    output logic [CIM_OUT_W-1:0]  rsp_data,
    output logic                  cmd_err,
    output logic                  busy,
    output logic                  mac_cs,
    output logic                  mac_web,
    output logic                  mac_cimeb,
    output logic [ADDR_WIDTH-1:0] mac_addr,
    output logic [DATA_WIDTH-1:0] mac_wdata,
    output logic [CIM_IN_W-1:0]   mac_cim_in,
    input  logic [DATA_WIDTH-1:0] mac_rdata,
    input  logic [CIM_OUT_W-1:0]  mac_cim_out
);
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, cnt_q, cnt_d;
    logic [CIM_IN_W-1:0]   cim_q, cim_d;
    logic [CIM_OUT_W-1:0]  rsp_data_q, rsp_data_d;
    logic                  rsp_is_cim_q, rsp_is_cim_d, err_q, err_d;
    logic                  wr_st, rd_st, ci_st, wr_go;

    assign wr_st = state_q == WRITE;
    assign rd_st = state_q == RD_ISSUE || state_q == RD_CAP;
    assign ci_st = state_q == CIM_ISSUE || state_q == CIM_CAP;
    assign wr_go = wr_st && wr_valid;

    assign cmd_ready  = rst_n && state_q == IDLE;
    assign busy       = state_q != IDLE;
    assign wr_ready   = wr_st;
    assign rsp_valid  = state_q == RESP;
    assign rsp_data   = rsp_data_q;
    assign rsp_is_cim = rsp_is_cim_q;
    assign cmd_err    = err_q;

    // Controls are held constant across ISSUE and CAP since the macro gates its outputs on the live pins
    assign mac_cs     = wr_go || rd_st || ci_st;
    assign mac_web    = !wr_go;
    assign mac_cimeb  = !ci_st;
    assign mac_addr   = (wr_st || rd_st || ci_st) ? addr_q : '0;
    assign mac_wdata  = wr_go ? wr_data : '0;
    assign mac_cim_in = ci_st ? cim_q : '0;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        cim_d        = cim_q;
        rsp_data_d   = rsp_data_q;
        rsp_is_cim_d = rsp_is_cim_q;
        err_d        = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid && cmd_ready) begin
                addr_d = cmd_addr;
                case (cmd_op_e'(cmd_op))
                    OP_WRITE: begin
                        state_d = WRITE;
                        cnt_d   = cmd_len;
                    end
                    OP_READ:  state_d = RD_ISSUE;
                    OP_CIM: begin
                        state_d = CIM_ISSUE;
                        cim_d   = cmd_cim_in;
                    end
                    default:  err_d = 1'b1;
                endcase
            end
            WRITE: if (wr_valid) begin
                addr_d  = addr_q + 1'b1;
                cnt_d   = cnt_q - 1'b1;
                state_d = cnt_q == '0 ? IDLE : WRITE;
            end
            RD_ISSUE:  state_d = RD_CAP;
            RD_CAP: begin
                rsp_data_d   = {{(CIM_OUT_W-DATA_WIDTH){1'b0}}, mac_rdata};
                rsp_is_cim_d = 1'b0;
                state_d      = RESP;
            end
            CIM_ISSUE: state_d = CIM_CAP;
            CIM_CAP: begin
                rsp_data_d   = mac_cim_out;
                rsp_is_cim_d = 1'b1;
                state_d      = RESP;
            end
            RESP:      state_d = rsp_ready ? IDLE : RESP;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            cim_q        <= '0;
            rsp_data_q   <= '0;
            rsp_is_cim_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            cim_q        <= cim_d;
            rsp_data_q   <= rsp_data_d;
            rsp_is_cim_q <= rsp_is_cim_d;
            err_q        <= err_d;
        end
    end
endmodule

// File: tb/tb_cim_macro_scheduler.sv
// tb_cim_macro_scheduler: randomized self-checking bench with a behavioural macro and a reference memory
module tb_cim_macro_scheduler;
    logic         clk = 1'b0, rst_n = 1'b0;
    logic         cmd_valid = 1'b0, cmd_ready;
    logic [1:0]   cmd_op = 2'd0;
    logic [9:0]   cmd_addr = '0, cmd_len = '0;
    logic [63:0]  cmd_cim_in = '0;
    logic         wr_valid = 1'b0, wr_ready;
    logic [7:0]   wr_data = '0;
    logic         rsp_valid, rsp_ready = 1'b0, rsp_is_cim, cmd_err, busy;
    logic [127:0] rsp_data;
    logic         mac_cs, mac_web, mac_cimeb;
    logic [9:0]   mac_addr;
    logic [7:0]   mac_wdata, mac_rdata = '0;
    logic [63:0]  mac_cim_in;
    logic [127:0] mac_cim_out = '0;
    logic [7:0]   mmem    [1024] = '{default: '0};
    logic [7:0]   ref_mem [1024] = '{default: '0};
    int           checks = 0, passes = 0;

    always #5 clk = ~clk;

    cim_macro_scheduler dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_cim_in(cmd_cim_in), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_data(wr_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_is_cim(rsp_is_cim), .rsp_data(rsp_data), .cmd_err(cmd_err), .busy(busy),
        .mac_cs(mac_cs), .mac_web(mac_web), .mac_cimeb(mac_cimeb), .mac_addr(mac_addr),
        .mac_wdata(mac_wdata), .mac_cim_in(mac_cim_in), .mac_rdata(mac_rdata), .mac_cim_out(mac_cim_out)
    );

    // Synchronous macro: one-cycle read/compute latency, lane j = nibble j times weight at addr+j
    always @(posedge clk) begin
        if (mac_cs && !mac_web) mmem[mac_addr] <= mac_wdata;
        else if (mac_cs && !mac_cimeb)
            for (int j = 0; j < 16; j++) mac_cim_out[j*8 +: 8] <= 8'(mac_cim_in[j*4 +: 4] * mmem[mac_addr + 10'(j)]);
        else if (mac_cs) mac_rdata <= mmem[mac_addr];
    end

    always @(negedge clk) begin
        checks++;
        if (!mac_web && !mac_cimeb) $display("FAIL web_cimeb_both_low: web=%b cimeb=%b want not both 0", mac_web, mac_cimeb);
        else passes++;
    end

    function automatic logic [127:0] exp_cim(input logic [9:0] a, input logic [63:0] v);
        logic [127:0] r;
        for (int j = 0; j < 16; j++) r[j*8 +: 8] = 8'((int'(v[j*4 +: 4]) * int'(ref_mem[10'(a + 10'(j))])) % 256);
        return r;
    endfunction

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [9:0] a, input logic [7:0] d [$], input int gap_at, input int gap_pct);
        logic [255:0] g, w;
        logic [9:0]   ea;
        int           k;
        cyc;
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = a; cmd_len = 10'(d.size() - 1);
        @(negedge clk);
        g = {cmd_ready, busy, mac_cs}; w = 3'b100; checks++;
        if (g !== w) $display("FAIL wr_accept: got %h want %h", g, w); else passes++;
        cyc;
        cmd_valid = 1'b0; cmd_addr = 10'($urandom);
        k = 0;
        while (k < d.size()) begin
            if (k == gap_at || $urandom_range(99) < gap_pct) begin
                wr_valid = 1'b0; wr_data = 8'($urandom);
                if (k == gap_at) gap_at = -1;
                @(negedge clk);
                g = {wr_ready, mac_cs, busy}; w = 3'b101; checks++;
                if (g !== w) $display("FAIL wr_gap: got %h want %h", g, w); else passes++;
            end else begin
                wr_valid = 1'b1; wr_data = d[k]; ea = a + 10'(k);
                @(negedge clk);
                g = {wr_ready, mac_cs, mac_web, mac_cimeb, mac_addr, mac_wdata}; w = {4'b1101, ea, d[k]}; checks++;
                if (g !== w) $display("FAIL wr_word%0d: got %h want %h", k, g, w); else passes++;
                ref_mem[ea] = d[k];
                k++;
            end
            cyc;
        end
        wr_valid = 1'b0;
        @(negedge clk);
        g = {busy, cmd_ready, wr_ready}; w = 3'b010; checks++;
        if (g !== w) $display("FAIL wr_done: got %h want %h", g, w); else passes++;
    endtask

    task automatic do_access(input logic [1:0] op, input logic [9:0] a, input logic [63:0] v, input int hold);
        logic [255:0] g, w;
        logic [127:0] exp_d;
        logic         is_c;
        is_c  = op == 2'd2;
        exp_d = is_c ? exp_cim(a, v) : {120'd0, ref_mem[a]};
        cyc;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_cim_in = v; cmd_len = 10'($urandom);
        @(negedge clk);
        g = {cmd_ready, busy, mac_cs}; w = 3'b100; checks++;
        if (g !== w) $display("FAIL acc_accept: got %h want %h", g, w); else passes++;
        cyc;
        cmd_valid = 1'b0; cmd_addr = 10'($urandom); cmd_cim_in = {$urandom, $urandom};
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            g = {rsp_valid, mac_cs, mac_web, mac_cimeb, mac_addr, mac_cim_in};
            w = {1'b0, 1'b1, 1'b1, !is_c, a, is_c ? v : 64'd0}; checks++;
            if (g !== w) $display("FAIL acc_pins%0d op%0d: got %h want %h", c, op, g, w); else passes++;
            cyc;
        end
        for (int c = 0; c <= hold; c++) begin
            rsp_ready = c == hold;
            @(negedge clk);
            g = {rsp_valid, rsp_is_cim, cmd_ready, busy, mac_cs, mac_cimeb}; w = {1'b1, is_c, 4'b0101}; checks++;
            if (g !== w) $display("FAIL rsp_ctl%0d: got %h want %h", c, g, w); else passes++;
            checks++;
            if (rsp_data !== exp_d) $display("FAIL rsp_data%0d op%0d: got %h want %h", c, op, rsp_data, exp_d); else passes++;
            cyc;
        end
        rsp_ready = 1'b0;
        @(negedge clk);
        g = {busy, cmd_ready, rsp_valid}; w = 3'b010; checks++;
        if (g !== w) $display("FAIL rsp_done: got %h want %h", g, w); else passes++;
    endtask

    task automatic test_reset;
        logic [255:0] g, w;
        @(negedge clk);
        g = {cmd_ready, busy, wr_ready, rsp_valid, rsp_is_cim, cmd_err, rsp_data, mac_cs, mac_web, mac_cimeb, mac_addr, mac_wdata, mac_cim_in};
        w = {6'b0, 128'd0, 3'b011, 10'd0, 8'd0, 64'd0}; checks++;
        if (g !== w) $display("FAIL reset_vals: got %h want %h", g, w); else passes++;
        cyc; cyc;
        rst_n = 1'b1;
        @(negedge clk);
        g = {cmd_ready, busy}; w = 2'b10; checks++;
        if (g !== w) $display("FAIL reset_release: got %h want %h", g, w); else passes++;
    endtask

    task automatic test_write_wrap;
        logic [7:0] dq [$];
        dq = {8'h11, 8'h22, 8'h33, 8'h44};
        do_write(10'h3FE, dq, 2, 0);
    endtask

    task automatic test_read;
        logic [7:0] dq [$];
        dq = {8'hA5};
        do_write(10'h005, dq, -1, 0);
        do_access(2'd1, 10'h005, 64'd0, 0);
        do_access(2'd1, 10'h000, 64'd0, 0);
    endtask

    task automatic test_hold;
        do_access(2'd1, 10'h3FF, 64'd0, 5);
        do_access(2'd2, 10'h3FE, 64'h0123_4567_89AB_CDEF, 5);
    endtask

    task automatic test_compute;
        logic [7:0] dq [$];
        for (int j = 0; j < 16; j++) dq.push_back(8'(j * 7 + 3));
        do_write(10'h100, dq, -1, 20);
        do_access(2'd2, 10'h100, 64'h1111_1111_1111_1111, 0);
        do_access(2'd2, 10'h104, {$urandom, $urandom}, 1);
    endtask

    task automatic test_bad_op;
        logic [255:0] g, w;
        cyc;
        cmd_valid = 1'b1; cmd_op = 2'd3; cmd_addr = 10'($urandom);
        @(negedge clk);
        g = {cmd_ready, cmd_err, busy}; w = 3'b100; checks++;
        if (g !== w) $display("FAIL bad_accept: got %h want %h", g, w); else passes++;
        cyc;
        cmd_valid = 1'b0;
        @(negedge clk);
        g = {cmd_err, busy, cmd_ready, wr_ready, mac_cs, mac_web, mac_cimeb}; w = 7'b1010011; checks++;
        if (g !== w) $display("FAIL bad_pulse: got %h want %h", g, w); else passes++;
        cyc;
        @(negedge clk);
        g = {cmd_err, busy}; w = 2'b00; checks++;
        if (g !== w) $display("FAIL bad_clear: got %h want %h", g, w); else passes++;
    endtask

    task automatic test_reset_mid;
        logic [255:0] g, w;
        logic [7:0]   dq [$];
        cyc;
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_addr = 10'h100; cmd_cim_in = 64'h1111_1111_1111_1111;
        cyc;
        cmd_valid = 1'b0;
        @(negedge clk);
        g = {mac_cs, mac_cimeb, busy}; w = 3'b101; checks++;
        if (g !== w) $display("FAIL rst_cim_issue: got %h want %h", g, w); else passes++;
        rst_n = 1'b0;
        #1;
        g = {cmd_ready, busy, wr_ready, rsp_valid, rsp_is_cim, cmd_err, rsp_data, mac_cs, mac_web, mac_cimeb, mac_addr, mac_wdata, mac_cim_in};
        w = {6'b0, 128'd0, 3'b011, 10'd0, 8'd0, 64'd0}; checks++;
        if (g !== w) $display("FAIL rst_mid_cim: got %h want %h", g, w); else passes++;
        cyc; cyc;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            g = {rsp_valid, busy, cmd_ready}; w = 3'b001; checks++;
            if (g !== w) $display("FAIL post_rst_cim%0d: got %h want %h", c, g, w); else passes++;
            cyc;
        end
        for (int k = 0; k < 6; k++) dq.push_back(8'($urandom_range(1, 255)));
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 10'h200; cmd_len = 10'd5;
        cyc;
        cmd_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wr_valid = 1'b1; wr_data = dq[k]; ref_mem[10'h200 + 10'(k)] = dq[k];
            cyc;
        end
        wr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        g = {cmd_ready, busy, wr_ready, rsp_valid, rsp_is_cim, cmd_err, rsp_data, mac_cs, mac_web, mac_cimeb, mac_addr, mac_wdata, mac_cim_in};
        w = {6'b0, 128'd0, 3'b011, 10'd0, 8'd0, 64'd0}; checks++;
        if (g !== w) $display("FAIL rst_mid_burst: got %h want %h", g, w); else passes++;
        cyc;
        rst_n = 1'b1;
        @(negedge clk);
        g = {rsp_valid, busy, cmd_ready}; w = 3'b001; checks++;
        if (g !== w) $display("FAIL post_rst_burst: got %h want %h", g, w); else passes++;
        do_access(2'd1, 10'h201, 64'd0, 0);
        do_access(2'd1, 10'h202, 64'd0, 0);
    endtask

    task automatic test_random;
        logic [7:0] dq [$];
        logic [9:0] a;
        int         n;
        for (int i = 0; i < 8; i++) begin
            dq.delete();
            a = 10'($urandom);
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) dq.push_back(8'($urandom));
            do_write(a, dq, -1, 30);
            do_access(2'd1, a + 10'($urandom_range(0, n - 1)), 64'd0, $urandom_range(0, 3));
            do_access(2'd2, a - 10'($urandom_range(0, 8)), {$urandom, $urandom}, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset;
        test_write_wrap;
        test_read;
        test_hold;
        test_compute;
        test_bad_op;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
